// File: rtl/aes_gf_pkg.sv
// Types, basis-change/affine matrices and GF(2^2) helpers for the composite-field AES S-box.
// GF(2^4) uses the normal basis (a^8, a^2) over GF(2^2) normal basis (w^2, w).
package aes_gf_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] nibble_t;

  // Column j (bits [8j+7:8j]) is the image of input bit j.
  typedef logic [7:0][7:0] mat_t;

  // Polynomial basis -> {ah, al}, where x = ah*Y + al and Y^2 + Y + NU = 0.
  localparam mat_t ISO_FWD = {8'h18, 8'hC3, 8'hD2, 8'hC8, 8'h99, 8'h91, 8'h39, 8'h0F};
  localparam mat_t ISO_INV = {8'h64, 8'h78, 8'h6E, 8'h8C, 8'h0C, 8'h51, 8'hB0, 8'hEC};

  localparam mat_t  AFF_MAT     = {8'h8F, 8'hC7, 8'hE3, 8'hF1, 8'hF8, 8'h7C, 8'h3E, 8'h1F};
  localparam byte_t AFF_C       = 8'h63;
  localparam mat_t  INV_AFF_MAT = {8'h25, 8'h92, 8'h49, 8'hA4, 8'h52, 8'h29, 8'h94, 8'h4A};
  localparam byte_t INV_AFF_C   = 8'h05;

  localparam nibble_t NU = 4'h1;

  function automatic logic [1:0] gf4_mul(logic [1:0] x, logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  // Squaring in a normal basis is a swap; it is also the GF(2^2) inverse.
  function automatic logic [1:0] gf4_sq(logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] gf4_scl_n(logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic byte_t mat_mul(mat_t m, byte_t x);
    byte_t y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      if (x[j]) y ^= m[j];
    end
    return y;
  endfunction

endpackage

// File: rtl/gf16_inv.sv
// Combinational GF(2^4) inverter: x^-1 = N(x)^-1 * conj(x), with N(x) = x * conj(x) in GF(2^2).
module gf16_inv
  import aes_gf_pkg::*;
(
  input  nibble_t x,
  output nibble_t y
);

  nibble_t conj;
  nibble_t norm;
  nibble_t norm_inv;

  // The conjugate swaps coordinates in this basis; the norm lands in GF(2^2) as {n, n}.
  assign conj     = {x[1:0], x[3:2]};
  assign norm_inv = {gf4_sq(norm[3:2]), gf4_sq(norm[1:0])};

  spem u_norm (
    .a(x),
    .b(conj),
    .p(norm)
  );

  spem u_res (
    .a(norm_inv),
    .b(conj),
    .p(y)
  );

endmodule

// File: rtl/spem.sv
// GF(2^4) multiplier over GF(2^2), normal basis (a^8, a^2).
module spem
  import aes_gf_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  output nibble_t p
);

  logic [1:0] e;

  assign e = gf4_scl_n(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
  assign p = {gf4_mul(a[3:2], b[3:2]) ^ e, gf4_mul(a[1:0], b[1:0]) ^ e};

endmodule

// File: rtl/sbox_pipe.sv
// Three-stage pipelined AES SubBytes over NBYTES lanes with valid/ready handshake.
// Optional inverse S-box selected per word when SBOX_INV_EN is defined.
module sbox_pipe
  import aes_gf_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
`ifdef SBOX_INV_EN
  input  logic                inv,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data
);

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  // Stage 1 per lane: {ah, al, d}; stage 2: {hi, lo}; stage 3: result byte.
  logic [NBYTES-1:0][11:0] s1_d, s1_q;
  logic [NBYTES-1:0][7:0]  s2_d, s2_q;
  logic [NBYTES-1:0][7:0]  s3_d, s3_q;

`ifdef SBOX_INV_EN
  logic m1_q, m2_q;
`endif

  always_comb begin
    ld3 = !v3_q || out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
  end

  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign out_data  = s3_q;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    byte_t   x_in, y_iso, back;
    nibble_t ah_sq, ah_sq_nu, ah_al, al_sq, d_inv;

`ifdef SBOX_INV_EN
    assign x_in = inv ? (mat_mul(INV_AFF_MAT, in_data[8*i+:8]) ^ INV_AFF_C) : in_data[8*i+:8];
`else
    assign x_in = in_data[8*i+:8];
`endif
    assign y_iso = mat_mul(ISO_FWD, x_in);

    spem u_ah_sq (.a(y_iso[7:4]), .b(y_iso[7:4]), .p(ah_sq));
    spem u_nu    (.a(ah_sq),      .b(NU),         .p(ah_sq_nu));
    spem u_ah_al (.a(y_iso[7:4]), .b(y_iso[3:0]), .p(ah_al));
    spem u_al_sq (.a(y_iso[3:0]), .b(y_iso[3:0]), .p(al_sq));

    assign s1_d[i] = {y_iso, ah_sq_nu ^ ah_al ^ al_sq};

    gf16_inv u_inv (
      .x(s1_q[i][3:0]),
      .y(d_inv)
    );

    spem u_hi (.a(s1_q[i][11:8]),                  .b(d_inv), .p(s2_d[i][7:4]));
    spem u_lo (.a(s1_q[i][11:8] ^ s1_q[i][7:4]),   .b(d_inv), .p(s2_d[i][3:0]));

    assign back = mat_mul(ISO_INV, s2_q[i]);
`ifdef SBOX_INV_EN
    assign s3_d[i] = m2_q ? back : (mat_mul(AFF_MAT, back) ^ AFF_C);
`else
    assign s3_d[i] = mat_mul(AFF_MAT, back) ^ AFF_C;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
`ifdef SBOX_INV_EN
      m1_q <= 1'b0;
      m2_q <= 1'b0;
`endif
    end else begin
      if (ld1) v1_q <= in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (ld1 && in_valid) s1_q <= s1_d;
      if (ld2 && v1_q)     s2_q <= s2_d;
      if (ld3 && v2_q)     s3_q <= s3_d;
`ifdef SBOX_INV_EN
      if (ld1 && in_valid) m1_q <= inv;
      if (ld2 && v1_q)     m2_q <= m1_q;
`endif
    end
  end

endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: GF(2^8) arithmetic reference model plus in-order scoreboard.
module tb_sbox_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        inv_s = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  fwd_t [256];
  logic [7:0]  inv_t [256];
  logic [31:0] exp_q [$];
  int          acc_q [$];
  bit          chk_lat = 1'b0;
  int          n_acc = 0;
  int          n_out = 0;

  sbox_pipe #(.NBYTES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef SBOX_INV_EN
    .inv(inv_s),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, cycles=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] model(logic [31:0] w, logic m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = m ? inv_t[w[8*i+:8]] : fwd_t[w[8*i+:8]];
    return r;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      b = 8'h01;
      for (int k = 0; k < 254; k++) b = gmul(b, 8'(x));
      if (x == 0) b = 8'h00;
      fwd_t[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  end

  // Scoreboard: sampled mid-cycle, when handshake signals are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, inv_s));
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("out_unexpected", 32'(exp_q.size()), 32'd1);
        else begin
          check("out_data", out_data, exp_q.pop_front());
          if (chk_lat) check("latency", 32'(cyc - acc_q.pop_front()), 32'd3);
          else void'(acc_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    inv_s    = m;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_next(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_data, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int          t0;
    int          seen;
    bit          done;

    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    idle(1);

    // Single word, then the FIPS-197 spot values.
    chk_lat = 1'b1;
    send(32'h53020100, 1'b0);
    expect_next("first_word", 32'hED777C63);
    @(negedge clk);
    check("one_cycle_valid", {31'd0, out_valid}, 32'd0);
    idle(1);
    send(32'h3010FF00, 1'b0);
    expect_next("fips_spot", 32'h04CA1663);
    idle(2);

    // All byte values in every lane, back to back.
    t0 = cyc;
    for (int k = 0; k < 256; k++) begin
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i+:8] = 8'(k + 64 * i);
      send(w, 1'b0);
    end
    check("throughput", 32'(cyc - t0), 32'd256);
    idle(6);
    chk_lat = 1'b0;

`ifdef SBOX_INV_EN
    send(32'h53020100, 1'b0);
    send(32'hED777C63, 1'b1);
    expect_next("mixed_fwd", 32'hED777C63);
    expect_next("mixed_inv", 32'h53020100);
    idle(2);
`endif

    // Backpressure: three words fill the pipe, a fourth waits.
    out_ready = 1'b0;
    send(32'h00112233, 1'b0);
    send(32'h44556677, 1'b0);
    send(32'h8899AABB, 1'b0);
    fork
      send(32'hCCDDEEFF, 1'b0);
      begin
        @(negedge clk);
        held = out_data;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_data", held, model(32'h00112233, 1'b0));
        repeat (4) begin
          @(negedge clk);
          check("stall_stable", out_data, held);
          check("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("accept_release", {31'd0, in_ready & out_valid}, 32'd1);
      end
    join
    idle(6);
    check("bp_no_loss", 32'(n_out), 32'(n_acc));

    // Random valid/ready over 1000 words.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send($urandom, 1'(`ifdef SBOX_INV_EN $urandom_range(0, 1) `else 0 `endif));
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    idle(8);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(n_out), 32'(n_acc));

    // Reset with three words in flight.
    out_ready = 1'b0;
    send(32'h01020304, 1'b0);
    send(32'h05060708, 1'b0);
    send(32'h090A0B0C, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    exp_q.delete();
    acc_q.delete();
    out_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_out", 32'(seen), 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    idle(1);
    send(32'h53020100, 1'b0);
    expect_next("post_rst_word", 32'hED777C63);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
